// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with synchronous clear/load, count enable and a 1-in-DIV prescaler.
// Latency: clr/load/step land on out one edge after sampling; wrap pulses the cycle after a wrapping edge; tc is combinational.
// No backpressure: en gates prescaler progress, and every enabled edge is consumed.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   en        count enable, qualifies prescaler advance
//   up        direction, 1 = increment, 0 = decrement (sampled on the stepping edge)
//   clr       synchronous clear to 0 (highest priority)
//   load      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  value to load
//   out       registered count value
//   tc        terminal count: (up & out==MODULUS-1) | (!up & out==0)
//   wrap      registered one-cycle pulse after out wraps across a bound
//
// Build option: define MOD_COUNTER_SAT_EN for saturating mode. The counter then holds at
// the bound instead of wrapping, and wrap stays 0. The prescaler cycles as usual.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  // Prescaler needs at least one bit even when DIV == 1 (it then never leaves 0).
  localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);

  logic [WIDTH-1:0] r_out;
  logic [PW-1:0]    r_pre;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_pre_last;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_wrap;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_max   = (r_out == MAX_VAL);
  assign w_at_zero  = (r_out == '0);
  assign w_pre_last = (r_pre == PRE_LAST);

  // Out-of-range loads clamp to the top of the count range.
  assign w_load_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Value and wrap flag the counter takes if this edge is a stepping edge.
  // The explicit bound compare is kept even when MODULUS == 2^WIDTH, where
  // the natural WIDTH-bit overflow would give the same value.
  always_comb begin
    w_step_val  = r_out;
    w_step_wrap = 1'b0;
`ifdef MOD_COUNTER_SAT_EN
    if (up) begin
      w_step_val = w_at_max ? MAX_VAL : (r_out + ONE);
    end else begin
      w_step_val = w_at_zero ? '0 : (r_out - ONE);
    end
`else
    if (up) begin
      w_step_val  = w_at_max ? '0 : (r_out + ONE);
      w_step_wrap = w_at_max;
    end else begin
      w_step_val  = w_at_zero ? MAX_VAL : (r_out - ONE);
      w_step_wrap = w_at_zero;
    end
`endif
  end

  // Priority: clr > load > enabled step. wrap only survives a single cycle
  // because every branch that does not step rewrites it to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_pre  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_out  <= '0;
      r_pre  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_out  <= w_load_val;
      r_pre  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (w_pre_last) begin
        r_pre  <= '0;
        r_out  <= w_step_val;
        r_wrap <= w_step_wrap;
      end else begin
        r_pre  <= r_pre + PRE_ONE;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out  = r_out;
  assign tc   = (up & w_at_max) | (~up & w_at_zero);
`ifdef MOD_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (DIV=1 and DIV=4) share one random/directed
// input stream and are compared every cycle against an integer reference model.
// Summary line reports comparisons made and comparisons failed.
module tb_mod_counter;

  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] out1, out4;
  logic       tc1, tc4, wrap1, wrap4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: index 0 is DIV=1, index 1 is DIV=4.
  int m_out [2];
  int m_pre [2];
  int m_wrap[2];
  int m_div [2] = '{1, 4};

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(MOD), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out1), .tc(tc1), .wrap(wrap1)
  );

  mod_counter #(.WIDTH(4), .MODULUS(MOD), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out4), .tc(tc4), .wrap(wrap4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i]  = 0;
      m_pre[i]  = 0;
      m_wrap[i] = 0;
    end
  endfunction

  // One clock edge of the counting rules, in plain integer arithmetic.
  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      if (clr) begin
        m_out[i] = 0;
        m_pre[i] = 0;
      end else if (load) begin
        m_out[i] = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == m_div[i]) begin
          m_pre[i] = 0;
`ifdef MOD_COUNTER_SAT_EN
          if (up) m_out[i] = (m_out[i] + 1 > MOD - 1) ? MOD - 1 : m_out[i] + 1;
          else    m_out[i] = (m_out[i] - 1 < 0) ? 0 : m_out[i] - 1;
`else
          if (up) begin
            m_wrap[i] = (m_out[i] == MOD - 1) ? 1 : 0;
            m_out[i]  = (m_out[i] + 1) % MOD;
          end else begin
            m_wrap[i] = (m_out[i] == 0) ? 1 : 0;
            m_out[i]  = (m_out[i] + MOD - 1) % MOD;
          end
`endif
        end
      end
    end
  endfunction

  function automatic int model_tc(input int i);
    return ((up && m_out[i] == MOD - 1) || (!up && m_out[i] == 0)) ? 1 : 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".out1"},  out1,  m_out[0]);
    check({tag, ".wrap1"}, wrap1, m_wrap[0]);
    check({tag, ".tc1"},   tc1,   model_tc(0));
    check({tag, ".out4"},  out4,  m_out[1]);
    check({tag, ".wrap4"}, wrap4, m_wrap[1]);
    check({tag, ".tc4"},   tc4,   model_tc(1));
  endtask

  // Apply inputs, take one rising edge through the model, compare on the falling edge.
  task automatic cyc(input string tag, input bit e, input bit u, input bit c,
                     input bit l, input logic [3:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset state, with tc following up.
    #2;
    compare_all("rst");
    up = 1'b0;
    #1;
    check("rst.tc_down", tc1, 1);
    up = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Up wrap on DIV=1: 10 edges from 0.
    cyc("clr0", 0, 1, 1, 0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      cyc("upwrap", 1, 1, 0, 0, 4'd0);
`ifndef MOD_COUNTER_SAT_EN
      if (k == 9) begin
        check("upwrap.out9", out1, 9);
        check("upwrap.tc9", tc1, 1);
      end
      if (k == 10) begin
        check("upwrap.out0", out1, 0);
        check("upwrap.wrap", wrap1, 1);
      end
`endif
    end
    cyc("wrapclear", 0, 1, 0, 0, 4'd0);
    check("wrap.onecycle", wrap1, 0);

    // Down wrap from 0, first holding without en.
    cyc("clr1", 0, 0, 1, 0, 4'd0);
    cyc("hold", 0, 0, 0, 0, 4'd0);
    check("hold.out", out1, 0);
    check("hold.tc", tc1, 1);
    cyc("downwrap", 1, 0, 0, 0, 4'd0);
`ifdef MOD_COUNTER_SAT_EN
    check("sat.down0", out1, 0);
    check("sat.wrap", wrap1, 0);
`else
    check("downwrap.out", out1, 9);
    check("downwrap.wrap", wrap1, 1);
`endif

    // Load, clamp, clr beats load; load does not step even with en.
    cyc("load7", 1, 1, 0, 1, 4'd7);
    check("load7.out", out1, 7);
    cyc("load12", 0, 1, 0, 1, 4'd12);
    check("load12.clamp", out1, 9);
`ifdef MOD_COUNTER_SAT_EN
    cyc("satup", 1, 1, 0, 0, 4'd0);
    check("sat.up9", out1, 9);
    check("sat.upwrap", wrap1, 0);
`endif
    cyc("clrload", 1, 1, 1, 1, 4'd5);
    check("clrload.out", out1, 0);

    // Prescale on DIV=4: en gaps stretch the step, load restarts the phase.
    cyc("clr2", 0, 1, 1, 0, 4'd0);
    for (int k = 0; k < 2; k++) cyc("pre.a", 1, 1, 0, 0, 4'd0);
    for (int k = 0; k < 3; k++) cyc("pre.gap", 0, 1, 0, 0, 4'd0);
    cyc("pre.b", 1, 1, 0, 0, 4'd0);
    check("pre.nostep", out4, 0);
    cyc("pre.c", 1, 1, 0, 0, 4'd0);
    check("pre.step", out4, 1);
    for (int k = 0; k < 2; k++) cyc("pre.d", 1, 1, 0, 0, 4'd0);
    cyc("pre.load", 1, 1, 0, 1, 4'd3);
    for (int k = 0; k < 3; k++) cyc("pre.e", 1, 1, 0, 0, 4'd0);
    check("pre.phase_hold", out4, 3);
    cyc("pre.f", 1, 1, 0, 0, 4'd0);
    check("pre.phase_step", out4, 4);

    // Asynchronous reset mid-count and mid-prescale.
    cyc("ld5", 0, 1, 0, 1, 4'd5);
    cyc("mid", 1, 1, 0, 0, 4'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check("arst.out1", out1, 0);
    check("arst.out4", out4, 0);
    check("arst.wrap1", wrap1, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compare_all("inrst");
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) cyc("postrst", 1, 1, 0, 0, 4'd0);
    check("postrst.out4", out4, 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc("rand",
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 29) == 0),
          4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter with synchronous load, clear, count enable and clock prescaler. It succeeds the fixed 2-bit free-running counter: width, modulus and step rate are configurable, and it adds direction control, terminal-count and wrap indications. It is used as a general event/timebase counter in the logic-circuit library.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 1.
- MODULUS, 10: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- DIV, 1: prescale ratio; out steps once per DIV enabled cycles; DIV ≥ 1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  count enable; qualifies prescaler advance.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  registered count value.
- tc  out  1  combinational terminal count: (up & out==MODULUS-1) | (!up & out==0).
- wrap  out  1  registered one-cycle pulse after out wraps across a bound.

## Operation
- Priority per edge: clr > load > step. No step occurs on a clr or load edge.
- clr: out←0, prescaler←0, wrap←0.
- load: out←load_val if load_val < MODULUS, else out←MODULUS-1 (clamped). Prescaler←0, wrap←0.
- Prescaler: internal counter 0..DIV-1, advances only when en=1. On the en edge where prescaler==DIV-1, prescaler←0 and out steps. With DIV=1, every en edge steps.
- Step up: out==MODULUS-1 → out←0, wrap←1; otherwise out←out+1.
- Step down: out==0 → out←MODULUS-1, wrap←1; otherwise out←out-1.
- wrap is 0 on every edge that does not wrap.
- en=0: out and prescaler hold; wrap←0.
- Changing up mid-prescale does not reset the prescaler; direction is sampled on the stepping edge.
- All arithmetic is done in WIDTH bits. MODULUS==2^WIDTH needs no compare-wrap overflow handling, but the explicit bound compare is still required.

## Timing
- Async reset: out=0, prescaler=0, wrap=0 immediately on rst=0, independent of clk. tc then reflects up (1 if up=0, 0 if up=1 for MODULUS>1).
- Reset deassertion is sampled synchronously; the first step occurs at the first qualifying edge after rst=1.
- Latency: load/clr/step are visible on out one edge after sampling. wrap is high exactly the cycle following the wrapping edge.
- tc is combinational from out and up, with no register delay.
- Reset mid-prescale discards partial prescale progress.

## Configuration
- MOD_COUNTER_SAT_EN defined: saturating mode. A step up at MODULUS-1 holds MODULUS-1, and a step down at 0 holds 0. wrap is tied to 0. The prescaler still cycles.
- Not defined: wrapping behaviour as in Operation.

## Test plan
- Reset: with rst=0 for 2 cycles mid-count at out=5, out=0 and wrap=0 at once, before any clk edge.
- Up wrap (MODULUS=10, DIV=1, en=1, up=1): 10 edges from 0 give out=9 then 0, with wrap=1 for exactly one cycle and tc=1 while out=9.
- Down wrap: from out=0, up=0, en=1 gives out=9 after one edge and wrap=1. Without en, out holds at 0 and tc=1.
- Load/clr: load_val=7 with load=1 gives out=7 and no step. load_val=12 gives out=9 (clamp). clr=1 and load=1 together give out=0.
- Prescale (DIV=4): en=1 continuously steps out every 4th edge. Dropping en for 3 cycles mid-prescale delays the step by 3 cycles. load resets the phase.
- Saturate (MOD_COUNTER_SAT_EN): stepping up at out=9 holds 9 with wrap=0. Stepping down at 0 holds 0.
